// File: rtl/eda_pkg.sv
// Shared types and window/neighbour index constants for the local-max raster scanner.
package eda_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} scan_state_e;

    // Window slots counted from the LSB: DR is slot 0, UL is slot 8.
    localparam int SLOT_DR = 0;
    localparam int SLOT_D  = 1;
    localparam int SLOT_DL = 2;
    localparam int SLOT_R  = 3;
    localparam int SLOT_C  = 4;
    localparam int SLOT_L  = 5;
    localparam int SLOT_UR = 6;
    localparam int SLOT_U  = 7;
    localparam int SLOT_UL = 8;

    localparam int NB_DR  = 0;
    localparam int NB_D   = 1;
    localparam int NB_DL  = 2;
    localparam int NB_R   = 3;
    localparam int NB_L   = 4;
    localparam int NB_UR  = 5;
    localparam int NB_U   = 6;
    localparam int NB_UL  = 7;
    localparam int NUM_NB = 8;

    // Neighbour bits skip the center slot, so bits at or above L shift up by one.
    function automatic int nb_slot(input int nb);
        return (nb >= NB_L) ? nb + 1 : nb;
    endfunction

endpackage

// File: rtl/eda_window_cmp.sv
// Combinational 3x3 local-max test: center >= every valid neighbour (unsigned, ties win).
module eda_window_cmp
    import eda_pkg::*;
#(
    parameter int PIXEL_WIDTH  = 8,
    parameter int WINDOW_WIDTH = 9
) (
    input  logic [WINDOW_WIDTH*PIXEL_WIDTH-1:0] window_values,
    input  logic [NUM_NB-1:0]                   neigh_addr_valid,
    output logic [PIXEL_WIDTH-1:0]              center,
    output logic                                is_max
);

    always_comb begin
        center = window_values[SLOT_C*PIXEL_WIDTH +: PIXEL_WIDTH];
        is_max = 1'b1;
        for (int k = 0; k < NUM_NB; k++) begin
            if (neigh_addr_valid[k] &&
                (window_values[nb_slot(k)*PIXEL_WIDTH +: PIXEL_WIDTH] > center))
                is_max = 1'b0;
        end
    end

endmodule

// File: rtl/eda_local_max_scan.sv
// Raster-scan local-max flagger feeding a valid/ready result stream.
// Optional EDA_MAX_COUNT_EN adds max_count, the number of local maxima handed downstream.
module eda_local_max_scan
    import eda_pkg::*;
#(
    parameter int M            = 16,
    parameter int N            = 16,
    parameter int PIXEL_WIDTH  = 8,
    parameter int WINDOW_WIDTH = 9,
    parameter int I_WIDTH      = $clog2(N),
    parameter int J_WIDTH      = $clog2(M),
    parameter int ADDR_WIDTH   = I_WIDTH + J_WIDTH
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                start,
    input  logic [WINDOW_WIDTH*PIXEL_WIDTH-1:0] window_values,
    input  logic [NUM_NB-1:0]                   neigh_addr_valid,
    output logic [ADDR_WIDTH-1:0]               center_addr,
    output logic                                busy,
    output logic                                done,
    output logic                                res_valid,
    input  logic                                res_ready,
    output logic [ADDR_WIDTH-1:0]               res_addr,
    output logic                                res_is_max,
    output logic [PIXEL_WIDTH-1:0]              res_pixel
`ifdef EDA_MAX_COUNT_EN
    ,
    output logic [ADDR_WIDTH:0]                 max_count
`endif
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    scan_state_e              state, state_nxt;
    logic                     start_acc, capture, clear_valid;
    logic [PIXEL_WIDTH-1:0]   c_pixel;
    logic                     c_is_max;

    eda_window_cmp #(
        .PIXEL_WIDTH  (PIXEL_WIDTH),
        .WINDOW_WIDTH (WINDOW_WIDTH)
    ) u_cmp (
        .window_values    (window_values),
        .neigh_addr_valid (neigh_addr_valid),
        .center           (c_pixel),
        .is_max           (c_is_max)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        start_acc   = 1'b0;
        capture     = 1'b0;
        clear_valid = 1'b0;
        case (state)
            IDLE: if (start) begin
                start_acc = 1'b1;
                state_nxt = SCAN;
            end
            SCAN: if (!res_valid || res_ready) begin
                capture = 1'b1;
                if (center_addr == LAST_ADDR) state_nxt = DRAIN;
            end
            // res_valid is always set here: the last capture filled the slot.
            DRAIN: if (res_ready) begin
                clear_valid = 1'b1;
                state_nxt   = DONE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == SCAN) || (state == DRAIN);
    assign done = (state == DONE);

    // {i, j} with power-of-two M: a plain +1 wraps j into an i increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            center_addr <= '0;
            res_valid   <= 1'b0;
            res_addr    <= '0;
            res_is_max  <= 1'b0;
            res_pixel   <= '0;
        end else begin
            if (start_acc)
                center_addr <= '0;
            else if (capture && center_addr != LAST_ADDR)
                center_addr <= center_addr + 1'b1;

            if (capture) begin
                res_valid  <= 1'b1;
                res_addr   <= center_addr;
                res_is_max <= c_is_max;
                res_pixel  <= c_pixel;
            end else if (clear_valid) begin
                res_valid  <= 1'b0;
            end
        end
    end

`ifdef EDA_MAX_COUNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            max_count <= '0;
        else if (start_acc)
            max_count <= '0;
        else if (res_valid && res_ready && res_is_max)
            max_count <= max_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_eda_local_max_scan.sv
// Directed bench for eda_local_max_scan: behavioural image RAM plus vector table of expected results.
module tb_eda_local_max_scan;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [71:0] window_values;
    logic [7:0]  neigh_addr_valid;
    logic [7:0]  center_addr;
    logic        busy, done, res_valid, res_ready, res_is_max;
    logic [7:0]  res_addr, res_pixel;
`ifdef EDA_MAX_COUNT_EN
    logic [8:0]  max_count;
`endif

    eda_local_max_scan dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .window_values    (window_values),
        .neigh_addr_valid (neigh_addr_valid),
        .center_addr      (center_addr),
        .busy             (busy),
        .done             (done),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_addr         (res_addr),
        .res_is_max       (res_is_max),
        .res_pixel        (res_pixel)
`ifdef EDA_MAX_COUNT_EN
        ,
        .max_count        (max_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    // Image RAM: out-of-image neighbours read 8'hFF so an unmasked compare would show up.
    logic [7:0] img [0:255];

    always_comb begin
        int ci, cj, ni, nj, slot, nb;
        window_values    = '0;
        neigh_addr_valid = '0;
        ci = int'(center_addr[7:4]);
        cj = int'(center_addr[3:0]);
        for (int di = -1; di <= 1; di++) begin
            for (int dj = -1; dj <= 1; dj++) begin
                ni   = ci + di;
                nj   = cj + dj;
                slot = 8 - ((di + 1) * 3 + (dj + 1));
                nb   = (slot > 4) ? slot - 1 : slot;
                if (ni >= 0 && ni < 16 && nj >= 0 && nj < 16) begin
                    window_values[slot*8 +: 8] = img[ni*16 + nj];
                    if (slot != 4) neigh_addr_valid[nb] = 1'b1;
                end else begin
                    window_values[slot*8 +: 8] = 8'hFF;
                end
            end
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic load_image(input int kind);
        for (int a = 0; a < 256; a++) begin
            case (kind)
                2:       img[a] = 8'h20;
                3:       img[a] = (a == 8'h57) ? 8'h80 : 8'h10;
                default: img[a] = 8'h00;
            endcase
        end
        if (kind == 4) begin
            img[8'h00] = 8'h05;
            img[8'h01] = 8'h04;
            img[8'h10] = 8'h04;
            img[8'h11] = 8'h05;
            img[8'hFF] = 8'hFF;
        end
    endtask

    typedef struct {
        int         img;
        logic [7:0] addr;
        logic       exp_max;
        logic [7:0] exp_pix;
    } vec_t;

    vec_t vecs[$];

    logic       got_max [0:255];
    logic [7:0] got_pix [0:255];
    int beats, ord_err, stall_err, done_gap;
    logic ready_pat [0:3];

    // mode 0: ready held high; mode 1: ready follows 1,0,0,1.
    // abort_at: return once that many beats are seen; restart_at: pulse start at that beat count.
    task automatic run_scan(input int mode, input int abort_at, input int restart_at);
        int last_cyc;
        logic stalled;
        logic [7:0] s_addr, s_pix;
        logic s_max;
        beats = 0; ord_err = 0; stall_err = 0; done_gap = -1;
        last_cyc = 0; stalled = 1'b0;
        s_addr = '0; s_pix = '0; s_max = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            res_ready = (mode == 0) ? 1'b1 : ready_pat[cyc % 4];
            start     = (beats == restart_at);
            @(negedge clk);
            if (done) begin
                done_gap = cyc - last_cyc;
                break;
            end
            if (stalled && (res_addr != s_addr || res_pix_ne(s_pix) || res_is_max != s_max))
                stall_err++;
            stalled = 1'b0;
            if (res_valid && res_ready) begin
                if (res_addr != 8'(beats)) ord_err++;
                got_max[res_addr] = res_is_max;
                got_pix[res_addr] = res_pixel;
                beats++;
                last_cyc = cyc;
                if (beats == abort_at) begin
                    start = 1'b0;
                    return;
                end
            end else if (res_valid) begin
                stalled = 1'b1;
                s_addr  = res_addr;
                s_pix   = res_pixel;
                s_max   = res_is_max;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    function automatic logic res_pix_ne(input logic [7:0] p);
        return res_pixel != p;
    endfunction

    task automatic check_table(input int kind, input string tag);
        foreach (vecs[v]) begin
            if (vecs[v].img == kind) begin
                chk($sformatf("%s_max@%02h", tag, vecs[v].addr), int'(got_max[vecs[v].addr]), int'(vecs[v].exp_max));
                chk($sformatf("%s_pix@%02h", tag, vecs[v].addr), int'(got_pix[vecs[v].addr]), int'(vecs[v].exp_pix));
            end
        end
    endtask

    task automatic check_done_pulse(input string tag);
        chk({tag, "_done_gap"}, done_gap, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, int'(done), 0);
        chk({tag, "_busy_after"}, int'(busy), 0);
    endtask

    initial begin
        int bad, done_seen, exp_m;
        ready_pat[0] = 1'b1; ready_pat[1] = 1'b0; ready_pat[2] = 1'b0; ready_pat[3] = 1'b1;

        vecs.push_back('{2, 8'h00, 1'b1, 8'h20});
        vecs.push_back('{2, 8'h64, 1'b1, 8'h20});
        vecs.push_back('{2, 8'hFF, 1'b1, 8'h20});
        vecs.push_back('{3, 8'h57, 1'b1, 8'h80});
        vecs.push_back('{3, 8'h46, 1'b0, 8'h10});
        vecs.push_back('{3, 8'h47, 1'b0, 8'h10});
        vecs.push_back('{3, 8'h48, 1'b0, 8'h10});
        vecs.push_back('{3, 8'h56, 1'b0, 8'h10});
        vecs.push_back('{3, 8'h58, 1'b0, 8'h10});
        vecs.push_back('{3, 8'h66, 1'b0, 8'h10});
        vecs.push_back('{3, 8'h67, 1'b0, 8'h10});
        vecs.push_back('{3, 8'h68, 1'b0, 8'h10});
        vecs.push_back('{3, 8'h45, 1'b1, 8'h10});
        vecs.push_back('{3, 8'h59, 1'b1, 8'h10});
        vecs.push_back('{3, 8'h00, 1'b1, 8'h10});
        vecs.push_back('{4, 8'h00, 1'b1, 8'h05});
        vecs.push_back('{4, 8'h01, 1'b0, 8'h04});
        vecs.push_back('{4, 8'h10, 1'b0, 8'h04});
        vecs.push_back('{4, 8'h11, 1'b1, 8'h05});
        vecs.push_back('{4, 8'hFF, 1'b1, 8'hFF});
        vecs.push_back('{4, 8'hEE, 1'b0, 8'h00});
        vecs.push_back('{4, 8'h22, 1'b0, 8'h00});
        vecs.push_back('{4, 8'h02, 1'b0, 8'h00});
        vecs.push_back('{4, 8'hF0, 1'b1, 8'h00});
        vecs.push_back('{4, 8'h0F, 1'b1, 8'h00});
        vecs.push_back('{4, 8'h55, 1'b1, 8'h00});

        // Test 1: reset and idle
        start = 1'b0; res_ready = 1'b0; reset_n = 1'b0;
        load_image(0);
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_valid", int'(res_valid), 0);
        chk("rst_center", int'(center_addr), 0);
        chk("rst_res_addr", int'(res_addr), 0);
        chk("rst_res_max", int'(res_is_max), 0);
        chk("rst_res_pix", int'(res_pixel), 0);
`ifdef EDA_MAX_COUNT_EN
        chk("rst_max_count", int'(max_count), 0);
`endif
        @(posedge clk); #1; reset_n = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done || busy || res_valid || center_addr != 0) done_seen++;
        end
        chk("idle_quiet", done_seen, 0);
        @(posedge clk); #1;

        // Test 2: flat image
        load_image(2);
        run_scan(0, -1, -1);
        chk("flat_beats", beats, 256);
        chk("flat_order", ord_err, 0);
        bad = 0;
        for (int a = 0; a < 256; a++) if (got_max[a] !== 1'b1) bad++;
        chk("flat_all_max", bad, 0);
        check_table(2, "flat");
`ifdef EDA_MAX_COUNT_EN
        chk("flat_max_count", int'(max_count), 256);
`endif
        check_done_pulse("flat");
`ifdef EDA_MAX_COUNT_EN
        chk("flat_max_count_hold", int'(max_count), 256);
`endif
        @(posedge clk); #1;

        // Test 3: single peak at {5,7}
        load_image(3);
        run_scan(0, -1, -1);
        chk("peak_beats", beats, 256);
        chk("peak_order", ord_err, 0);
        bad = 0;
        for (int a = 0; a < 256; a++) begin
            exp_m = ((a / 16) >= 4 && (a / 16) <= 6 && (a % 16) >= 6 && (a % 16) <= 8 && a != 8'h57) ? 0 : 1;
            if (int'(got_max[a]) != exp_m) bad++;
        end
        chk("peak_all_max", bad, 0);
        check_table(3, "peak");
`ifdef EDA_MAX_COUNT_EN
        chk("peak_max_count", int'(max_count), 248);
`endif
        check_done_pulse("peak");
        @(posedge clk); #1;

        // Test 4: corner and edge masking
        load_image(4);
        run_scan(0, -1, -1);
        chk("edge_beats", beats, 256);
        check_table(4, "edge");
        check_done_pulse("edge");
        @(posedge clk); #1;

        // Test 5: backpressure 1,0,0,1
        load_image(3);
        run_scan(1, -1, -1);
        chk("bp_beats", beats, 256);
        chk("bp_order", ord_err, 0);
        chk("bp_stall_stable", stall_err, 0);
        check_table(3, "bp");
`ifdef EDA_MAX_COUNT_EN
        chk("bp_max_count", int'(max_count), 248);
`endif
        check_done_pulse("bp");
        @(posedge clk); #1;

        // Test 6: reset at beat 100, start pulse at beat 50 ignored
        load_image(4);
        run_scan(0, 100, 50);
        chk("mid_beats", beats, 100);
        chk("mid_order", ord_err, 0);
        chk("mid_busy_before", int'(busy), 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_valid", int'(res_valid), 0);
        chk("mid_rst_center", int'(center_addr), 0);
        chk("mid_rst_res_addr", int'(res_addr), 0);
        chk("mid_rst_res_pix", int'(res_pixel), 0);
`ifdef EDA_MAX_COUNT_EN
        chk("mid_rst_max_count", int'(max_count), 0);
`endif
        @(posedge clk); #1; reset_n = 1'b1;
        @(posedge clk); #1;
        run_scan(0, -1, -1);
        chk("rerun_beats", beats, 256);
        chk("rerun_order", ord_err, 0);
        check_table(4, "rerun");
        check_done_pulse("rerun");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
